// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   - timer_state_t : idle-timeout FSM states for the receive buffer
//   - UART_DATA_W   : width of one UART character
//   - UART_RX_FIFO_DEPTH_DEFAULT : default receive buffer depth
package uart_pkg;

  localparam int unsigned UART_DATA_W                = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ARMED,
    T_FIRED
  } timer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented on rdata_o whenever
// the FIFO is non-empty (driven to zero when empty).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write wdata_i (accepted if not full, or if a pop happens too)
//   pop_i      : advance the head (ignored when empty)
//   wdata_i    : write data
//   rdata_o    : head entry
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
//   count_o    : occupancy 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_en  = pop_i & ~empty_o;
  // When full, the slot being popped is the one the write lands in.
  assign push_en = push_i & (~full_o | pop_en);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + CW'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; rdata_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Captures one byte per rising
// edge of rx_data_ready_i, buffers it in a show-ahead FIFO and offers it on a
// valid/ready interface. Flags dropped bytes (sticky) and pulses timeout_o
// when buffered bytes sit unread for TIMEOUT_TICKS ticks with no new byte.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   tick_i             : baud tick, used only by the idle timer
//   rx_data_i          : received byte
//   rx_data_ready_i    : byte-complete level from the receiver
//   m_data_o/m_valid_o : head byte / non-empty
//   m_ready_i          : consumer accepts head byte
//   count_o, full_o    : occupancy, count_o == DEPTH
//   overflow_o         : sticky drop flag, cleared by clear_overflow_i
//   timeout_o          : one-cycle idle-timeout pulse
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = UART_RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_i,
  input  logic [UART_DATA_W-1:0]   rx_data_i,
  input  logic                     rx_data_ready_i,
  output logic [UART_DATA_W-1:0]   m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     overflow_o,
  input  logic                     clear_overflow_i,
  output logic                     timeout_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS) + 1;

  logic         prev_ready_q;
  logic         overflow_q, overflow_d;
  logic         timeout_q, timeout_d;
  logic [TW-1:0] tmr_cnt_q, tmr_cnt_d;
  timer_state_t tmr_state_q, tmr_state_d;

  logic push_req, push_acc, pop, empty, emptying;

  assign push_req = rx_data_ready_i & ~prev_ready_q;
  assign pop      = m_valid_o & m_ready_i;
  assign push_acc = push_req & (~full_o | pop);
  // Last byte leaves this cycle with nothing replacing it.
  assign emptying = pop & ~push_acc & (count_o == CW'(1));

  assign m_valid_o  = ~empty;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_acc),
    .pop_i   (pop),
    .wdata_i (rx_data_i),
    .rdata_o (m_data_o),
    .full_o  (full_o),
    .empty_o (empty),
    .count_o (count_o)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && full_o && !pop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    tmr_state_d = tmr_state_q;
    tmr_cnt_d   = tmr_cnt_q;
    timeout_d   = 1'b0;
    unique case (tmr_state_q)
      T_IDLE: begin
        tmr_cnt_d = '0;
        if (push_acc) tmr_state_d = T_ARMED;
      end
      T_ARMED: begin
        if (push_acc) begin
          tmr_cnt_d = '0;
        end else if (emptying) begin
          tmr_state_d = T_IDLE;
          tmr_cnt_d   = '0;
        end else if (tick_i) begin
          if (tmr_cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
            tmr_state_d = T_FIRED;
            timeout_d   = 1'b1;
          end else begin
            tmr_cnt_d = tmr_cnt_q + TW'(1);
          end
        end
      end
      T_FIRED: begin
        if (push_acc) begin
          tmr_state_d = T_ARMED;
          tmr_cnt_d   = '0;
        end else if (emptying) begin
          tmr_state_d = T_IDLE;
          tmr_cnt_d   = '0;
        end
      end
      default: begin
        tmr_state_d = T_IDLE;
        tmr_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Held high so a level already asserted at reset release is not captured.
      prev_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      tmr_cnt_q    <= '0;
      tmr_state_q  <= T_IDLE;
    end else begin
      prev_ready_q <= rx_data_ready_i;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      tmr_cnt_q    <= tmr_cnt_d;
      tmr_state_q  <= tmr_state_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clear_overflow;
  logic       timeout;

  int n_total = 0;
  int n_bad   = 0;
  int to_pulses = 0;
  int max_cnt = 0;
  bit rec_en = 0;
  logic [7:0] rx_q [$];

  uart_rx_fifo #(
    .DEPTH         (16),
    .TIMEOUT_TICKS (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tick_i           (tick),
    .rx_data_i        (rx_data),
    .rx_data_ready_i  (rx_data_ready),
    .m_data_o         (m_data),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready),
    .count_o          (count),
    .full_o           (full),
    .overflow_o       (overflow),
    .clear_overflow_i (clear_overflow),
    .timeout_o        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; inputs set before the call are what the edge sees.
  task automatic step();
    if (rec_en && m_valid && m_ready) rx_q.push_back(m_data);
    @(posedge clk);
    #1;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (timeout) to_pulses++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    step();
  endtask

  // Tick arrives after 15 idle clocks.
  task automatic tick_period();
    for (int i = 0; i < 15; i++) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    reset = 1'b1; tick = 1'b0; rx_data = 8'h00; rx_data_ready = 1'b0;
    m_ready = 1'b0; clear_overflow = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", count, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_mdata", m_data, 0);

    // Long data_ready level yields one entry.
    rx_data = 8'hA5; rx_data_ready = 1'b1;
    step();
    chk("t1_valid", m_valid, 1);
    chk("t1_data", m_data, 8'hA5);
    chk("t1_count", count, 1);
    for (int i = 0; i < 19; i++) step();
    rx_data_ready = 1'b0;
    step();
    chk("t1_count_hold", count, 1);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    chk("t1_drained", m_valid, 0);

    // Fill, overflow, ordered drain, clear.
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("t2_full", full, 1);
    chk("t2_count", count, 16);
    send_byte(8'hFF);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_ovf", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", m_data, 32'(i));
      m_ready = 1'b1; step(); m_ready = 1'b0;
    end
    chk("t2_empty", m_valid, 0);
    chk("t2_ovf_sticky", overflow, 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("t2_ovf_clr", overflow, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    rx_data = 8'h55; rx_data_ready = 1'b1; m_ready = 1'b1;
    step();
    rx_data_ready = 1'b0; m_ready = 1'b0;
    chk("t3_ovf", overflow, 0);
    chk("t3_count", count, 16);
    chk("t3_head", m_data, 8'h11);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'h55;
      chk("t3_drain", m_data, exp_b);
      m_ready = 1'b1; step(); m_ready = 1'b0;
    end
    chk("t3_empty", m_valid, 0);
    step();

    // Streaming with continuous m_ready.
    max_cnt = 0; rec_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_byte(8'(i * 37 + 5));
    for (int i = 0; i < 4; i++) step();
    rec_en = 1'b0; m_ready = 1'b0;
    chk("t4_n", rx_q.size(), 40);
    for (int i = 0; i < 40; i++) begin
      exp_b = 8'(i * 37 + 5);
      if (i < rx_q.size()) chk("t4_data", rx_q[i], exp_b);
    end
    chk("t4_maxcnt_le2", (max_cnt <= 2), 1);
    chk("t4_empty", m_valid, 0);

    // Idle timeout.
    send_byte(8'h31);
    to_pulses = 0;
    for (int i = 0; i < 3; i++) tick_period();
    chk("t5_no_early", to_pulses, 0);
    tick_period();
    chk("t5_pulse_now", timeout, 1);
    chk("t5_first", to_pulses, 1);
    for (int i = 0; i < 4; i++) tick_period();
    chk("t5_once", to_pulses, 1);
    send_byte(8'h32);
    for (int i = 0; i < 4; i++) tick_period();
    chk("t5_second", to_pulses, 2);
    send_byte(8'h33);
    for (int i = 0; i < 3; i++) tick_period();
    for (int i = 0; i < 15; i++) step();
    rx_data = 8'h34; rx_data_ready = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0; rx_data_ready = 1'b0;
    step();
    chk("t5_push_wins", to_pulses, 2);
    for (int i = 0; i < 3; i++) tick_period();
    chk("t5_restarted", to_pulses, 2);
    tick_period();
    chk("t5_third", to_pulses, 3);
    chk("t5_count", count, 4);

    // Reset with data buffered and overflow set.
    for (int i = 0; i < 13; i++) send_byte(8'h40 + 8'(i));
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    m_ready = 1'b0;
    chk("t6_count5", count, 5);
    chk("t6_ovf_set", overflow, 1);
    reset = 1'b1; rx_data_ready = 1'b1;
    step();
    chk("t6_count", count, 0);
    chk("t6_valid", m_valid, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_timeout", timeout, 0);
    reset = 1'b0;
    step(); step();
    chk("t6_nocap_count", count, 0);
    chk("t6_nocap_valid", m_valid, 0);
    rx_data_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
